shift_reg_universal: RTL and testbench

Parametrised universal shift register: a chain of DEPTH stages, each WIDTH bits wide, supporting hold, serial shift in either direction, rotate, parallel load and clear, with a fill counter that tracks how many stages hold valid shifted-in data. It replaces fixed 4-stage serial-in/serial-out shifters. It serves as the serialiser/deserialiser and delay-line primitive for datapath blocks in this design.

---
 rtl/shift_reg_universal.sv | 99 +++++++++
 tb/tb_shift_reg_universal.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_universal.sv
// Universal shift register: DEPTH stages of WIDTH bits with hold, shift, rotate,
// parallel load and clear, plus a saturating count of shifted-in stages.

module shift_reg_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go_r,
  input  logic             go_l,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] d_r,
  input  logic [WIDTH-1:0] d_l,
  input  logic [WIDTH-1:0] d_ld,
  output logic [WIDTH-1:0] q
);
  // Operation selects are mutually exclusive; the top decodes them from one mode.
  always_ff @(posedge clk) begin
    if (rst || clr)  q <= '0;
    else if (go_r)   q <= d_r;
    else if (go_l)   q <= d_l;
    else if (ld)     q <= d_ld;
  end
endmodule

module shift_reg_universal #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [2:0]             mode,
  input  logic [WIDTH-1:0]       sin_r,
  input  logic [WIDTH-1:0]       sin_l,
  input  logic [WIDTH*DEPTH-1:0] pload,
  output logic [WIDTH-1:0]       sout_r,
  output logic [WIDTH-1:0]       sout_l,
  output logic [WIDTH*DEPTH-1:0] pout,
  output logic [CW-1:0]          fill_cnt,
  output logic                   full
);
  typedef enum logic [2:0] {
    M_HOLD, M_SHR, M_SHL, M_ROR, M_ROL, M_LOAD, M_CLR, M_RSVD
  } mode_e;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  mode_e op;
  logic  go_r, go_l, ld, clr;
  logic  [DEPTH-1:0][WIDTH-1:0] stg, ld_v;
  logic  [CW-1:0] fill;

  assign op   = mode_e'(mode);
  assign go_r = en && (op == M_SHR || op == M_ROR);
  assign go_l = en && (op == M_SHL || op == M_ROL);
  assign ld   = en && (op == M_LOAD);
  assign clr  = en && (op == M_CLR);
  assign ld_v = pload;

  // End stages pick serial input or the wrapped-around opposite end for rotates.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] d_r, d_l;
    if (i == DEPTH-1) begin : g_rend
      assign d_r = (op == M_ROR) ? stg[0] : sin_r;
    end else begin : g_rmid
      assign d_r = stg[i+1];
    end
    if (i == 0) begin : g_lend
      assign d_l = (op == M_ROL) ? stg[DEPTH-1] : sin_l;
    end else begin : g_lmid
      assign d_l = stg[i-1];
    end
    shift_reg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk, .rst, .go_r, .go_l, .ld, .clr,
      .d_r, .d_l, .d_ld(ld_v[i]), .q(stg[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) fill <= '0;
    else if (en) begin
      case (op)
        M_SHR, M_SHL: if (fill != FULL_CNT) fill <= fill + 1'b1;
        M_LOAD:       fill <= FULL_CNT;
        M_CLR:        fill <= '0;
        default:      ;
      endcase
    end
  end

  assign sout_r   = stg[0];
  assign sout_l   = stg[DEPTH-1];
  assign pout     = stg;
  assign fill_cnt = fill;
  assign full     = (fill == FULL_CNT);
endmodule

// File: tb/tb_shift_reg_universal.sv
// Bench for shift_reg_universal: directed table and sequences on fixed configs,
// then a random sweep over several DEPTH/WIDTH configs against a queue model.

module tb_shift_reg_universal;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0, ntot = 0;

  // Directed instances share control; each has its own data path.
  logic rst, en;
  logic [2:0] mode;

  logic [7:0]  sr8, sl8, so8r, so8l;
  logic [31:0] pl8, po8;
  logic [2:0]  fc8;
  logic        fu8;
  logic        sr1, sl1, so1r, so1l;
  logic [3:0]  pl1, po1;
  logic [2:0]  fc1;
  logic        fu1;
  logic [3:0]  sr3, sl3, so3r, so3l;
  logic [11:0] pl3, po3;
  logic [1:0]  fc3;
  logic        fu3;
  logic [3:0]  sr4, sl4, so4r, so4l;
  logic [15:0] pl4, po4;
  logic [2:0]  fc4;
  logic        fu4;

  shift_reg_universal #(.WIDTH(8), .DEPTH(4)) u8 (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .sin_r(sr8), .sin_l(sl8), .pload(pl8), .sout_r(so8r), .sout_l(so8l), .pout(po8), .fill_cnt(fc8), .full(fu8));
  shift_reg_universal #(.WIDTH(1), .DEPTH(4)) u1 (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .sin_r(sr1), .sin_l(sl1), .pload(pl1), .sout_r(so1r), .sout_l(so1l), .pout(po1), .fill_cnt(fc1), .full(fu1));
  shift_reg_universal #(.WIDTH(4), .DEPTH(3)) u3 (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .sin_r(sr3), .sin_l(sl3), .pload(pl3), .sout_r(so3r), .sout_l(so3l), .pout(po3), .fill_cnt(fc3), .full(fu3));
  shift_reg_universal #(.WIDTH(4), .DEPTH(4)) u4 (.clk(clk), .rst(rst), .en(en), .mode(mode),
    .sin_r(sr4), .sin_l(sl4), .pload(pl4), .sout_r(so4r), .sout_l(so4l), .pout(po4), .fill_cnt(fc4), .full(fu4));

  // Sweep instances: signals sized for the largest config, zero-extended outputs.
  localparam int NSW = 6;
  localparam int DEP[NSW] = '{2, 2, 5, 5, 16, 16};
  localparam int WID[NSW] = '{1, 3, 1, 3, 1, 3};

  logic        srst, sen;
  logic [2:0]  smode;
  logic [2:0]  sinr_a [NSW];
  logic [2:0]  sinl_a [NSW];
  logic [47:0] pload_a[NSW];
  logic [47:0] pout_a [NSW];
  logic [2:0]  sor_a  [NSW];
  logic [2:0]  sol_a  [NSW];
  logic [4:0]  fill_a [NSW];
  logic        full_a [NSW];

  for (genvar k = 0; k < NSW; k++) begin : sw
    localparam int W = WID[k];
    localparam int D = DEP[k];
    logic [W*D-1:0]         po;
    logic [W-1:0]           sor, sol;
    logic [$clog2(D+1)-1:0] fc;
    logic                   fu;
    shift_reg_universal #(.WIDTH(W), .DEPTH(D)) u (.clk(clk), .rst(srst), .en(sen), .mode(smode),
      .sin_r(sinr_a[k][W-1:0]), .sin_l(sinl_a[k][W-1:0]), .pload(pload_a[k][W*D-1:0]),
      .sout_r(sor), .sout_l(sol), .pout(po), .fill_cnt(fc), .full(fu));
    assign pout_a[k] = 48'(po);
    assign sor_a[k]  = 3'(sor);
    assign sol_a[k]  = 3'(sol);
    assign fill_a[k] = 5'(fc);
    assign full_a[k] = fu;
  end

  typedef struct {
    string       name;
    logic        rst, en;
    logic [2:0]  mode;
    logic [7:0]  sr, sl;
    logic [31:0] pl;
    logic [31:0] ep;
    int          ef;
  } vec_t;
  vec_t tbl[15];

  logic [2:0] mq[NSW][$];
  int         mf[NSW];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0; en = 0; mode = 0;
    sr8 = 0; sl8 = 0; pl8 = 0; sr1 = 0; sl1 = 0; pl1 = 0;
    sr3 = 0; sl3 = 0; pl3 = 0; sr4 = 0; sl4 = 0; pl4 = 0;
    srst = 1; sen = 0; smode = 0;
    for (int k = 0; k < NSW; k++) begin
      sinr_a[k] = 0; sinl_a[k] = 0; pload_a[k] = 0;
    end

    //            name            rst en mode sr     sl     pload         exp pout      fill
    tbl[0]  = '{"garbage load",   0, 1, 5, 8'h00, 8'h00, 32'hDEADBEEF, 32'hDEADBEEF, 4};
    tbl[1]  = '{"reset over load",1, 1, 5, 8'h00, 8'h00, 32'hFFFFFFFF, 32'h00000000, 0};
    tbl[2]  = '{"load",           0, 1, 5, 8'h00, 8'h00, 32'h44332211, 32'h44332211, 4};
    tbl[3]  = '{"ror",            0, 1, 3, 8'hEE, 8'hEE, 32'h0,        32'h11443322, 4};
    tbl[4]  = '{"rol 1",          0, 1, 4, 8'hEE, 8'hEE, 32'h0,        32'h44332211, 4};
    tbl[5]  = '{"rol 2",          0, 1, 4, 8'hEE, 8'hEE, 32'h0,        32'h33221144, 4};
    tbl[6]  = '{"reserved",       0, 1, 7, 8'hFF, 8'hFF, 32'hFFFFFFFF, 32'h33221144, 4};
    tbl[7]  = '{"hold",           0, 1, 0, 8'hFF, 8'hFF, 32'hFFFFFFFF, 32'h33221144, 4};
    tbl[8]  = '{"en low shr",     0, 0, 1, 8'hAB, 8'h00, 32'h0,        32'h33221144, 4};
    tbl[9]  = '{"shr full",       0, 1, 1, 8'hAB, 8'h00, 32'h0,        32'hAB332211, 4};
    tbl[10] = '{"clr",            0, 1, 6, 8'h00, 8'h00, 32'h0,        32'h00000000, 0};
    tbl[11] = '{"shl",            0, 1, 2, 8'h00, 8'h5A, 32'h0,        32'h0000005A, 1};
    tbl[12] = '{"reset en low",   1, 0, 0, 8'h00, 8'h00, 32'h0,        32'h00000000, 0};
    tbl[13] = '{"shr after rst",  0, 1, 1, 8'h77, 8'h00, 32'h0,        32'h77000000, 1};
    tbl[14] = '{"shl dir change", 0, 1, 2, 8'h00, 8'h66, 32'h0,        32'h00000066, 2};

    tick();
    for (int r = 0; r < 15; r++) begin
      rst = tbl[r].rst; en = tbl[r].en; mode = tbl[r].mode;
      sr8 = tbl[r].sr; sl8 = tbl[r].sl; pl8 = tbl[r].pl;
      tick();
      chk({tbl[r].name, " pout"},   po8,  tbl[r].ep);
      chk({tbl[r].name, " fill"},   fc8,  tbl[r].ef);
      chk({tbl[r].name, " full"},   fu8,  tbl[r].ef == 4);
      chk({tbl[r].name, " sout_r"}, so8r, tbl[r].ep[7:0]);
      chk({tbl[r].name, " sout_l"}, so8l, tbl[r].ep[31:24]);
    end

    // SISO, WIDTH=1 DEPTH=4: reset after garbage, then serial latency and saturation.
    rst = 0; en = 1; mode = 5; pl1 = 4'hF;
    tick();
    chk("siso garbage load", po1, 4'hF);
    rst = 1;
    tick();
    chk("siso rst pout", po1, 0);
    chk("siso rst fill", fc1, 0);
    chk("siso rst full", fu1, 0);
    rst = 0; mode = 1;
    for (int b = 0; b < 4; b++) begin
      sr1 = (b == 1) ? 1'b0 : 1'b1;
      tick();
      if (b == 2) begin
        chk("siso latency sout_r", so1r, 0);
        chk("siso fill 3", fc1, 3);
        chk("siso not full", fu1, 0);
      end
    end
    chk("siso pout", po1, 4'b1101);
    chk("siso sout_r", so1r, 1);
    chk("siso fill 4", fc1, 4);
    chk("siso full", fu1, 1);
    sr1 = 0;
    tick();
    chk("siso 5th pout", po1, 4'b0110);
    chk("siso 5th fill", fc1, 4);

    // SHL with en gaps, WIDTH=4 DEPTH=3.
    mode = 6;
    tick();
    mode = 2; sl3 = 4'hA;
    tick();
    en = 0; sl3 = 4'hF;
    tick();
    tick();
    en = 1; sl3 = 4'h5;
    tick();
    chk("shl gap pout", po3, 12'h0A5);
    chk("shl gap fill", fc3, 2);
    chk("shl gap full", fu3, 0);
    chk("shl gap sout_r", so3r, 4'h5);
    sl3 = 4'hC;
    tick();
    chk("shl sat pout", po3, 12'hA5C);
    chk("shl sat fill", fc3, 3);
    chk("shl sat full", fu3, 1);
    chk("shl sat sout_l", so3l, 4'hA);

    // Reserved mode and HOLD keep the loaded word.
    mode = 5; pl4 = 16'h1234;
    tick();
    chk("rsvd load", po4, 16'h1234);
    for (int j = 0; j < 6; j++) begin
      mode = (j < 3) ? 3'd7 : 3'd0;
      sr4 = 4'($urandom); sl4 = 4'($urandom);
      tick();
      chk($sformatf("rsvd/hold mode%0d pout", mode), po4, 16'h1234);
      chk($sformatf("rsvd/hold mode%0d fill", mode), fc4, 4);
    end

    // Random sweep against a queue model: index 0 is stage 0.
    for (int cyc = 0; cyc < 400; cyc++) begin
      srst  = (cyc == 0) || ($urandom_range(0, 49) == 0);
      sen   = ($urandom_range(0, 9) != 0);
      smode = 3'($urandom_range(0, 7));
      if (smode == 3'd6 && $urandom_range(0, 3) != 0) smode = 3'd1;
      for (int k = 0; k < NSW; k++) begin
        int msk;
        logic [2:0] t;
        msk = (1 << WID[k]) - 1;
        sinr_a[k]  = 3'($urandom & msk);
        sinl_a[k]  = 3'($urandom & msk);
        pload_a[k] = 48'({$urandom, $urandom});
        if (srst) begin
          mq[k].delete();
          for (int i = 0; i < DEP[k]; i++) mq[k].push_back(3'd0);
          mf[k] = 0;
        end else if (sen) begin
          case (smode)
            3'd1: begin void'(mq[k].pop_front()); mq[k].push_back(sinr_a[k]);
                        mf[k] = (mf[k] < DEP[k]) ? mf[k] + 1 : DEP[k]; end
            3'd2: begin void'(mq[k].pop_back()); mq[k].push_front(sinl_a[k]);
                        mf[k] = (mf[k] < DEP[k]) ? mf[k] + 1 : DEP[k]; end
            3'd3: begin t = mq[k].pop_front(); mq[k].push_back(t); end
            3'd4: begin t = mq[k].pop_back(); mq[k].push_front(t); end
            3'd5: begin
              for (int i = 0; i < DEP[k]; i++)
                mq[k][i] = 3'((pload_a[k] >> (i * WID[k])) & 48'(msk));
              mf[k] = DEP[k];
            end
            3'd6: begin
              for (int i = 0; i < DEP[k]; i++) mq[k][i] = 3'd0;
              mf[k] = 0;
            end
            default: ;
          endcase
        end
      end
      tick();
      for (int k = 0; k < NSW; k++) begin
        logic [47:0] e;
        e = '0;
        for (int i = 0; i < DEP[k]; i++) e |= 48'(mq[k][i]) << (i * WID[k]);
        chk($sformatf("sweep d%0d w%0d cyc%0d pout", DEP[k], WID[k], cyc), pout_a[k], e);
        chk($sformatf("sweep d%0d w%0d cyc%0d fill", DEP[k], WID[k], cyc), fill_a[k], mf[k]);
        chk($sformatf("sweep d%0d w%0d cyc%0d full", DEP[k], WID[k], cyc), full_a[k], mf[k] == DEP[k]);
        chk($sformatf("sweep d%0d w%0d cyc%0d sout_r", DEP[k], WID[k], cyc), sor_a[k], mq[k][0]);
        chk($sformatf("sweep d%0d w%0d cyc%0d sout_l", DEP[k], WID[k], cyc), sol_a[k], mq[k][DEP[k]-1]);
      end
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
